adf4351_cfg_seq: RTL and testbench



---
 rtl/adf4351_pkg.sv | 52 +++++
 rtl/adf4351_word_build.sv | 64 ++++++
 rtl/adf4351_cfg_seq.sv | 268 ++++++++++++++++++++++++++
 tb/tb_adf4351_cfg_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adf4351_pkg.sv
// ---------------------------------------------------------------------------
// adf4351_pkg
// Shared definitions for the ADF4351 configuration sequencer:
//   - FSM state encodings
//   - register control-bit codes (the C3..C1 field in bits [2:0] of each word)
//   - ERR_CODE values reported to the host
//   - word counts for the full-init and retune sequences
//   - R0 word assembly helper
// ---------------------------------------------------------------------------
package adf4351_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_CHECK     = 4'd1;
    localparam state_t ST_LOAD      = 4'd2;
    localparam state_t ST_ISSUE     = 4'd3;
    localparam state_t ST_WAIT_DONE = 4'd4;
    localparam state_t ST_GAP       = 4'd5;
    localparam state_t ST_LOCK_WAIT = 4'd6;
    localparam state_t ST_FINISH    = 4'd7;
    localparam state_t ST_ERROR     = 4'd8;

    // Register address bits carried in the low three bits of every word.
    localparam logic [2:0] CTRL_R0 = 3'b000;
    localparam logic [2:0] CTRL_R1 = 3'b001;
    localparam logic [2:0] CTRL_R2 = 3'b010;
    localparam logic [2:0] CTRL_R3 = 3'b011;
    localparam logic [2:0] CTRL_R4 = 3'b100;
    localparam logic [2:0] CTRL_R5 = 3'b101;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_PARAMS = 2'd1;
    localparam logic [1:0] ERR_WRITE_TMO  = 2'd2;
    localparam logic [1:0] ERR_LOCK_TMO   = 2'd3;

    localparam int WORDS_FULL   = 6;
    localparam int WORDS_RETUNE = 3;

    // Smallest legal integer divider and modulus for the PLL.
    localparam int MIN_INT = 23;
    localparam int MIN_MOD = 2;

    // Consecutive synchronised lock-detect highs required before DONE.
    localparam int LOCK_RUN_CYCLES = 16;

    function automatic logic [31:0] make_r0(input logic [15:0] int_val,
                                            input logic [11:0] frac_val);
        return {1'b0, int_val, frac_val, CTRL_R0};
    endfunction

endpackage

// File: rtl/adf4351_word_build.sv
// ---------------------------------------------------------------------------
// adf4351_word_build
// Combinational word mux: selects the 32-bit register word for the current
// position in the write sequence.
//   Full init order : R5, R4, R3, R2, R1, R0
//   Retune order    : R4, R1, R0
// Ports:
//   idx      in  3   word position within the sequence
//   retune   in  1   0 = full init list, 1 = retune list
//   int_val  in  16  latched integer divider
//   frac_val in  12  latched fractional numerator
//   mod_val  in  12  latched modulus
//   rfdiv    in  3   latched output divider select
//   word     out 32  register word for position idx
// ---------------------------------------------------------------------------
module adf4351_word_build
    import adf4351_pkg::*;
#(
    parameter logic [31:0] R5_INIT = 32'h00580005,
    parameter logic [31:0] R3_INIT = 32'h008004B3,
    parameter logic [31:0] R2_INIT = 32'h00004E42,
    parameter logic [31:0] R4_BASE = 32'h008C803C,
    parameter logic [31:0] R1_BASE = 32'h08008011
) (
    input  logic [2:0]  idx,
    input  logic        retune,
    input  logic [15:0] int_val,
    input  logic [11:0] frac_val,
    input  logic [11:0] mod_val,
    input  logic [2:0]  rfdiv,
    output logic [31:0] word
);

    logic [31:0] r4_word;
    logic [31:0] r1_word;
    logic [31:0] r0_word;

    assign r4_word = {R4_BASE[31:23], rfdiv, R4_BASE[19:3], CTRL_R4};
    assign r1_word = {R1_BASE[31:15], mod_val, CTRL_R1};
    assign r0_word = make_r0(int_val, frac_val);

    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for word.
    always_comb begin
        word = r0_word;
        if (retune) begin
            case (idx)
                3'd0:    word = r4_word;
                3'd1:    word = r1_word;
                default: word = r0_word;
            endcase
        end else begin
            case (idx)
                3'd0:    word = R5_INIT;
                3'd1:    word = r4_word;
                3'd2:    word = R3_INIT;
                3'd3:    word = R2_INIT;
                3'd4:    word = r1_word;
                default: word = r0_word;
            endcase
        end
    end

endmodule

// File: rtl/adf4351_cfg_seq.sv
// ---------------------------------------------------------------------------
// adf4351_cfg_seq
// Configuration sequencer for the ADF4351 PLL. On START it validates the
// latched frequency fields, then feeds R5..R0 (full init) or R4,R1,R0
// (retune) one word at a time through the SPI writer handshake
// (WEN / WDATA / WRITE_DONE) and reports DONE or ERR to the host.
//
// Optional feature: define LOCK_WAIT_EN to add a lock-detect wait on
// ADF_MUXOUT after the last word (parameter LOCK_TIMEOUT).
//
// Ports:
//   CLK             in   1   system clock
//   RST             in   1   asynchronous active-high reset
//   START           in   1   1-cycle request, sampled only in IDLE
//   RETUNE          in   1   sampled with START: 0 = full init, 1 = retune
//   INT_VAL         in   16  integer divider
//   FRAC_VAL        in   12  fractional numerator
//   MOD_VAL         in   12  modulus
//   RFDIV           in   3   output divider select
//   ADF_WRITE_DONE  in   1   1-cycle completion pulse from SPI writer
//   ADF_MUXOUT      in   1   PLL lock detect (LOCK_WAIT_EN only)
//   ADF_WEN         out  1   1-cycle write request to SPI writer
//   ADF_WDATA       out  32  word to writer, stable from WEN to WRITE_DONE
//   BUSY            out  1   high from START acceptance through DONE/ERR
//   DONE            out  1   1-cycle pulse, sequence complete
//   ERR             out  1   1-cycle pulse, parameter reject or timeout
//   ERR_CODE        out  2   valid with ERR: 1 params, 2 write, 3 lock
// ---------------------------------------------------------------------------
module adf4351_cfg_seq
    import adf4351_pkg::*;
#(
    parameter logic [31:0] R5_INIT      = 32'h00580005,
    parameter logic [31:0] R3_INIT      = 32'h008004B3,
    parameter logic [31:0] R2_INIT      = 32'h00004E42,
    parameter logic [31:0] R4_BASE      = 32'h008C803C,
    parameter logic [31:0] R1_BASE      = 32'h08008011,
    parameter int          GAP_CYCLES   = 4,
    parameter int          DONE_TIMEOUT = 255
`ifdef LOCK_WAIT_EN
    ,
    parameter int          LOCK_TIMEOUT = 100000
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        RETUNE,
    input  logic [15:0] INT_VAL,
    input  logic [11:0] FRAC_VAL,
    input  logic [11:0] MOD_VAL,
    input  logic [2:0]  RFDIV,
    input  logic        ADF_WRITE_DONE,
    input  logic        ADF_MUXOUT,
    output logic        ADF_WEN,
    output logic [31:0] ADF_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CODE
);

    localparam int TMO_W = $clog2(DONE_TIMEOUT) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    state_t state_q;
    state_t state_d;

    logic        retune_q;
    logic [15:0] int_q;
    logic [11:0] frac_q;
    logic [11:0] mod_q;
    logic [2:0]  rfdiv_q;

    logic [2:0]       idx_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [1:0]       err_code_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word;

    logic params_bad;
    logic last_word;
    logic tmo_hit;
    logic gap_last;

    assign params_bad = (int_q < 16'(MIN_INT)) || (mod_q < 12'(MIN_MOD)) ||
                        (frac_q >= mod_q);
    assign last_word  = retune_q ? (idx_q == 3'(WORDS_RETUNE - 1))
                                 : (idx_q == 3'(WORDS_FULL - 1));
    // tmo_cnt_q is 0 in the WEN cycle, so leaving WAIT_DONE at count
    // DONE_TIMEOUT-1 puts the ERR pulse exactly DONE_TIMEOUT cycles after WEN.
    assign tmo_hit    = (tmo_cnt_q >= TMO_W'(DONE_TIMEOUT - 1));
    assign gap_last   = (gap_cnt_q >= GAP_W'(GAP_CYCLES - 1));

`ifdef LOCK_WAIT_EN
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT) + 1;

    logic              mux_meta_q;
    logic              mux_sync_q;
    logic [4:0]        lock_run_q;
    logic [LOCK_W-1:0] lock_tmo_q;
    logic              lock_ok;
    logic              lock_tmo_hit;

    assign lock_ok      = (lock_run_q == 5'(LOCK_RUN_CYCLES));
    assign lock_tmo_hit = (lock_tmo_q >= LOCK_W'(LOCK_TIMEOUT - 1));

    // Two-flop synchroniser for the asynchronous lock-detect pin, followed
    // by a run-length counter that restarts whenever lock drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mux_meta_q <= 1'b0;
            mux_sync_q <= 1'b0;
            lock_run_q <= '0;
            lock_tmo_q <= '0;
        end else begin
            mux_meta_q <= ADF_MUXOUT;
            mux_sync_q <= mux_meta_q;
            if (state_q == ST_LOCK_WAIT) begin
                if (!mux_sync_q)
                    lock_run_q <= '0;
                else if (!lock_ok)
                    lock_run_q <= lock_run_q + 5'd1;
                if (lock_tmo_q != '1)
                    lock_tmo_q <= lock_tmo_q + 1'b1;
            end else begin
                lock_run_q <= '0;
                lock_tmo_q <= '0;
            end
        end
    end
`else
    logic unused_muxout;
    assign unused_muxout = ADF_MUXOUT;
`endif

    adf4351_word_build #(
        .R5_INIT (R5_INIT),
        .R3_INIT (R3_INIT),
        .R2_INIT (R2_INIT),
        .R4_BASE (R4_BASE),
        .R1_BASE (R1_BASE)
    ) u_word_build (
        .idx      (idx_q),
        .retune   (retune_q),
        .int_val  (int_q),
        .frac_val (frac_q),
        .mod_val  (mod_q),
        .rfdiv    (rfdiv_q),
        .word     (word)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (START) state_d = ST_CHECK;
            ST_CHECK:     state_d = params_bad ? ST_ERROR : ST_LOAD;
            ST_LOAD:      state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // WRITE_DONE is tested first so it wins over a same-cycle timeout.
                if (ADF_WRITE_DONE)
                    state_d = ST_GAP;
                else if (tmo_hit)
                    state_d = ST_ERROR;
            end
            ST_GAP: begin
                if (gap_last) begin
                    if (!last_word)
                        state_d = ST_LOAD;
                    else
`ifdef LOCK_WAIT_EN
                        state_d = ST_LOCK_WAIT;
`else
                        state_d = ST_FINISH;
`endif
                end
            end
`ifdef LOCK_WAIT_EN
            ST_LOCK_WAIT: begin
                if (lock_ok)
                    state_d = ST_FINISH;
                else if (lock_tmo_hit)
                    state_d = ST_ERROR;
            end
`endif
            ST_FINISH:    state_d = ST_IDLE;
            ST_ERROR:     state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ADF_WEN  = (state_q == ST_ISSUE);
        BUSY     = (state_q != ST_IDLE);
        DONE     = (state_q == ST_FINISH);
        ERR      = (state_q == ST_ERROR);
        ERR_CODE = (state_q == ST_ERROR) ? err_code_q : ERR_NONE;
    end

    assign ADF_WDATA = wdata_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retune_q   <= 1'b0;
            int_q      <= '0;
            frac_q     <= '0;
            mod_q      <= '0;
            rfdiv_q    <= '0;
            idx_q      <= '0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            err_code_q <= ERR_NONE;
            wdata_q    <= '0;
        end else begin
            if (state_q == ST_IDLE && START) begin
                retune_q <= RETUNE;
                int_q    <= INT_VAL;
                frac_q   <= FRAC_VAL;
                mod_q    <= MOD_VAL;
                rfdiv_q  <= RFDIV;
            end

            if (state_q == ST_IDLE)
                idx_q <= '0;
            else if (state_q == ST_GAP && gap_last && !last_word)
                idx_q <= idx_q + 3'd1;

            if (state_q == ST_LOAD)
                wdata_q <= word;

            // Counts cycles since WEN; held at zero outside ISSUE/WAIT_DONE.
            if (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) begin
                if (tmo_cnt_q != '1)
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end

            if (state_q == ST_GAP) begin
                if (gap_cnt_q != '1)
                    gap_cnt_q <= gap_cnt_q + 1'b1;
            end else begin
                gap_cnt_q <= '0;
            end

            case (state_q)
                ST_IDLE:      err_code_q <= ERR_NONE;
                ST_CHECK:     if (params_bad) err_code_q <= ERR_BAD_PARAMS;
                ST_WAIT_DONE: if (!ADF_WRITE_DONE && tmo_hit) err_code_q <= ERR_WRITE_TMO;
`ifdef LOCK_WAIT_EN
                ST_LOCK_WAIT: if (!lock_ok && lock_tmo_hit) err_code_q <= ERR_LOCK_TMO;
`endif
                default:      err_code_q <= err_code_q;
            endcase
        end
    end

endmodule

// File: tb/tb_adf4351_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_adf4351_cfg_seq
// Self-checking bench for adf4351_cfg_seq. Stimulus pushes the expected
// words and the expected completion event into queues; a monitor pops and
// compares whenever the DUT raises ADF_WEN, DONE or ERR. A writer model
// answers each WEN with WRITE_DONE after a fixed delay.
// ---------------------------------------------------------------------------
module tb_adf4351_cfg_seq;

    localparam logic [31:0] W_R5 = 32'h00580005;
    localparam logic [31:0] W_R4 = 32'h00AC803C;  // RFDIV=2 in [22:20]
    localparam logic [31:0] W_R3 = 32'h008004B3;
    localparam logic [31:0] W_R2 = 32'h00004E42;
    localparam logic [31:0] W_R1 = 32'h080080C9;  // modulus of 25 in bits [14:3]
    localparam logic [31:0] W_R0 = 32'h00320028;  // INT=100, FRAC=5

    localparam int WRITER_DELAY = 131;
    localparam int DONE_TMO     = 255;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
    } evt_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        RETUNE = 1'b0;
    logic [15:0] INT_VAL = '0;
    logic [11:0] FRAC_VAL = '0;
    logic [11:0] MOD_VAL = '0;
    logic [2:0]  RFDIV = '0;
    logic        ADF_WRITE_DONE = 1'b0;
`ifdef LOCK_WAIT_EN
    logic        ADF_MUXOUT = 1'b1;
`else
    logic        ADF_MUXOUT = 1'b0;
`endif
    logic        ADF_WEN;
    logic [31:0] ADF_WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [1:0]  ERR_CODE;

    logic [31:0] wq[$];
    evt_t        eq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wen_count = 0;
    int evt_count = 0;
    int last_wen_cyc = 0;
    int last_evt_cyc = 0;
    int start_cyc = 0;
    bit writer_en = 1'b1;

    adf4351_cfg_seq #(
        .GAP_CYCLES   (4),
        .DONE_TIMEOUT (DONE_TMO)
`ifdef LOCK_WAIT_EN
        ,
        .LOCK_TIMEOUT (400)
`endif
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .RETUNE         (RETUNE),
        .INT_VAL        (INT_VAL),
        .FRAC_VAL       (FRAC_VAL),
        .MOD_VAL        (MOD_VAL),
        .RFDIV          (RFDIV),
        .ADF_WRITE_DONE (ADF_WRITE_DONE),
        .ADF_MUXOUT     (ADF_MUXOUT),
        .ADF_WEN        (ADF_WEN),
        .ADF_WDATA      (ADF_WDATA),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .ERR            (ERR),
        .ERR_CODE       (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writer model: answers each WEN with a 1-cycle WRITE_DONE.
    initial begin : writer
        forever begin
            @(negedge CLK);
            if (ADF_WEN && writer_en && !RST) begin
                repeat (WRITER_DELAY) @(posedge CLK);
                #1 ADF_WRITE_DONE = 1'b1;
                @(posedge CLK);
                #1 ADF_WRITE_DONE = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin : monitor
        evt_t e;
        forever begin
            @(negedge CLK);
            if (ADF_WEN) begin
                wen_count++;
                last_wen_cyc = cyc;
                if (wq.size() == 0)
                    check("unexpected_wen", ADF_WDATA, 32'hFFFF_FFFF ^ ADF_WDATA);
                else
                    check("wen_word", ADF_WDATA, wq.pop_front());
            end
            if (DONE || ERR) begin
                evt_count++;
                last_evt_cyc = cyc;
                if (eq.size() == 0) begin
                    check("unexpected_evt", {30'd0, DONE, ERR}, 32'd0);
                end else begin
                    e = eq.pop_front();
                    check("evt_err", ERR, e.is_err);
                    check("evt_done", DONE, !e.is_err);
                    check("evt_code", ERR_CODE, e.code);
                    check("evt_busy", BUSY, 1'b1);
                end
            end
        end
    end

    task automatic pulse_start(input logic rt, input logic [15:0] iv,
                               input logic [11:0] fv, input logic [11:0] mv,
                               input logic [2:0] rd);
        @(posedge CLK);
        #1;
        RETUNE = rt; INT_VAL = iv; FRAC_VAL = fv; MOD_VAL = mv; RFDIV = rd;
        START = 1'b1;
        start_cyc = cyc;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic push_full();
        wq.push_back(W_R5); wq.push_back(W_R4); wq.push_back(W_R3);
        wq.push_back(W_R2); wq.push_back(W_R1); wq.push_back(W_R0);
    endtask

    task automatic push_retune();
        wq.push_back(W_R4); wq.push_back(W_R1); wq.push_back(W_R0);
    endtask

    // Waits (bounded) for the next DONE/ERR, then checks the idle aftermath.
    task automatic wait_evt(input int base, input int budget, input string name);
        int n = 0;
        while (evt_count == base && n < budget) begin
            @(posedge CLK);
            n++;
        end
        check({name, "_evt_seen"}, evt_count != base, 1'b1);
        #1;
        check({name, "_busy_low"}, BUSY, 1'b0);
        check({name, "_words_left"}, wq.size(), 0);
        check({name, "_evts_left"}, eq.size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base_w;
        int base_e;
        int n;

        // Reset values.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_wen", ADF_WEN, 1'b0);
        check("rst_wdata", ADF_WDATA, 32'd0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_code", ERR_CODE, 2'd0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // Stray WRITE_DONE while idle must not start anything.
        #1 ADF_WRITE_DONE = 1'b1;
        @(posedge CLK);
        #1 ADF_WRITE_DONE = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check("stray_done_busy", BUSY, 1'b0);

        // Full init, with a START pulse while busy that must be ignored.
        push_full();
        eq.push_back('{is_err: 1'b0, code: 2'd0});
        base_w = wen_count; base_e = evt_count;
        pulse_start(1'b0, 16'd100, 12'd5, 12'd25, 3'd2);
        repeat (200) @(posedge CLK);
        #1 check("busy_mid_seq", BUSY, 1'b1);
        pulse_start(1'b1, 16'd30, 12'd1, 12'd3, 3'd7);
        wait_evt(base_e, 3000, "full");
        check("full_wen_count", wen_count - base_w, 6);

        // Retune.
        push_retune();
        eq.push_back('{is_err: 1'b0, code: 2'd0});
        base_w = wen_count; base_e = evt_count;
        pulse_start(1'b1, 16'd100, 12'd5, 12'd25, 3'd2);
        wait_evt(base_e, 2000, "retune");
        check("retune_wen_count", wen_count - base_w, 3);

        // Bad params: INT below 23.
        eq.push_back('{is_err: 1'b1, code: 2'd1});
        base_w = wen_count; base_e = evt_count;
        pulse_start(1'b0, 16'd22, 12'd5, 12'd25, 3'd2);
        wait_evt(base_e, 20, "bad_int");
        check("bad_int_latency", last_evt_cyc - start_cyc, 2);
        check("bad_int_no_wen", wen_count - base_w, 0);

        // Bad params: FRAC equal to MOD.
        eq.push_back('{is_err: 1'b1, code: 2'd1});
        base_w = wen_count; base_e = evt_count;
        pulse_start(1'b1, 16'd100, 12'd25, 12'd25, 3'd2);
        wait_evt(base_e, 20, "bad_frac");
        check("bad_frac_latency", last_evt_cyc - start_cyc, 2);
        check("bad_frac_no_wen", wen_count - base_w, 0);

        // Write timeout: the writer never answers.
        writer_en = 1'b0;
        wq.push_back(W_R5);
        eq.push_back('{is_err: 1'b1, code: 2'd2});
        base_w = wen_count; base_e = evt_count;
        pulse_start(1'b0, 16'd100, 12'd5, 12'd25, 3'd2);
        wait_evt(base_e, 600, "tmo");
        check("tmo_latency", last_evt_cyc - last_wen_cyc, DONE_TMO);
        check("tmo_wen_count", wen_count - base_w, 1);
        writer_en = 1'b1;

        // A new START after the timeout succeeds.
        push_retune();
        eq.push_back('{is_err: 1'b0, code: 2'd0});
        base_e = evt_count;
        pulse_start(1'b1, 16'd100, 12'd5, 12'd25, 3'd2);
        wait_evt(base_e, 2000, "after_tmo");

        // Reset while the third word's WEN is high.
        push_full();
        eq.push_back('{is_err: 1'b0, code: 2'd0});
        base_w = wen_count; base_e = evt_count;
        pulse_start(1'b0, 16'd100, 12'd5, 12'd25, 3'd2);
        n = 0;
        while (!(ADF_WEN && wen_count == base_w + 2) && n < 2000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("rst_mid_reached_w3", ADF_WEN, 1'b1);
        RST = 1'b1;
        #1;
        check("rst_mid_wen", ADF_WEN, 1'b0);
        check("rst_mid_busy", BUSY, 1'b0);
        check("rst_mid_done", DONE, 1'b0);
        check("rst_mid_err", ERR, 1'b0);
        wq.delete();
        eq.delete();
        repeat (5) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (300) @(posedge CLK);
        #1;
        check("rst_mid_idle_busy", BUSY, 1'b0);
        check("rst_mid_no_resume", wen_count - base_w, 2);
        check("rst_mid_no_evt", evt_count - base_e, 0);

        push_retune();
        eq.push_back('{is_err: 1'b0, code: 2'd0});
        base_e = evt_count;
        pulse_start(1'b1, 16'd100, 12'd5, 12'd25, 3'd2);
        wait_evt(base_e, 2000, "after_rst");

`ifdef LOCK_WAIT_EN
        // Lock arrives about 50 cycles after the last word completes.
        ADF_MUXOUT = 1'b0;
        push_retune();
        eq.push_back('{is_err: 1'b0, code: 2'd0});
        base_w = wen_count; base_e = evt_count;
        pulse_start(1'b1, 16'd100, 12'd5, 12'd25, 3'd2);
        n = 0;
        while (wen_count != base_w + 3 && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        repeat (WRITER_DELAY + 5 + 50) @(posedge CLK);
        #1 ADF_MUXOUT = 1'b1;
        n = cyc;
        wait_evt(base_e, 200, "lock");
        check("lock_latency_ok", (last_evt_cyc - n >= 18) && (last_evt_cyc - n <= 20), 1'b1);

        // Lock never arrives.
        ADF_MUXOUT = 1'b0;
        push_retune();
        eq.push_back('{is_err: 1'b1, code: 2'd3});
        base_e = evt_count;
        pulse_start(1'b1, 16'd100, 12'd5, 12'd25, 3'd2);
        wait_evt(base_e, 2000, "lock_tmo");
        ADF_MUXOUT = 1'b1;
`endif

        repeat (5) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
